// File: rtl/ir_sirc_receiver.sv
// SIRC-12 infrared frame decoder: start burst, then 12 pulse-width coded bits, LSB first.
// Optional IR_GLITCH_FILTER_EN adds a 2-of-3 majority filter on the enable-sampled input.
module ir_sirc_receiver #(
    parameter int START_MIN = 28,
    parameter int ONE_MIN   = 12,
    parameter int ZERO_MIN  = 4,
    parameter int HIGH_MAX  = 40,
    parameter int GAP_MAX   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ir_in,
    output logic [6:0] command,
    output logic [4:0] address,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for carrier
    // START | counting the start burst
    // GAP   | counting low samples between bursts
    // BIT   | counting a data burst, classified when it ends
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_BIT   = 2'd3;

    localparam logic [5:0] START_MIN_C = 6'(START_MIN);
    localparam logic [5:0] ONE_MIN_C   = 6'(ONE_MIN);
    localparam logic [5:0] ZERO_MIN_C  = 6'(ZERO_MIN);
    localparam logic [5:0] HIGH_MAX_C  = 6'(HIGH_MAX);
    localparam logic [5:0] GAP_MAX_C   = 6'(GAP_MAX);

    logic [1:0]  sync_q, sync_d;
    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] shift_q, shift_d, frame;
    logic [6:0]  command_q, command_d;
    logic [4:0]  address_q, address_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        sample;

    assign sync_d = {sync_q[0], ir_in};

`ifdef IR_GLITCH_FILTER_EN
    logic [2:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (enable) hist_d = {hist_q[1:0], sync_q[1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist_q <= 3'b000;
        else       hist_q <= hist_d;
    end

    assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
    assign sample = sync_q[1];
`endif

    assign cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
    // Shift right so the first received bit ends up at frame[0].
    assign frame   = {(cnt_q >= ONE_MIN_C), shift_q[11:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        command_d = command_q;
        address_d = address_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (sample) begin
                        state_d   = S_START;
                        cnt_d     = 6'd1;
                        bit_cnt_d = 4'd0;
                        shift_d   = 12'd0;
                    end
                end
                S_START: begin
                    if (sample) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc > HIGH_MAX_C) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (cnt_q >= START_MIN_C) begin
                        state_d = S_GAP;
                        cnt_d   = 6'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_GAP: begin
                    if (!sample) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc > GAP_MAX_C) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_BIT;
                        cnt_d   = 6'd1;
                    end
                end
                S_BIT: begin
                    if (sample) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc > HIGH_MAX_C) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (cnt_q < ZERO_MIN_C) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (bit_cnt_q == 4'd11) begin
                        shift_d   = frame;
                        command_d = frame[6:0];
                        address_d = frame[11:7];
                        valid_d   = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        shift_d   = frame;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = S_GAP;
                        cnt_d     = 6'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b00;
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 12'd0;
            command_q <= 7'd0;
            address_q <= 5'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            command_q <= command_d;
            address_q <= address_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign command = command_q;
    assign address = address_q;
    assign valid   = valid_q;
    assign error   = error_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_sirc_receiver.sv
// Bench for ir_sirc_receiver: directed and random sample streams checked against a run-length decoder model.
module tb_ir_sirc_receiver;

    localparam int START_MIN = 28;
    localparam int ONE_MIN   = 12;
    localparam int ZERO_MIN  = 4;
    localparam int HIGH_MAX  = 40;
    localparam int GAP_MAX   = 16;
    localparam int MAXS      = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       ir_in;
    logic [6:0] command;
    logic [4:0] address;
    logic       valid;
    logic       error;
    logic       busy;

    ir_sirc_receiver dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .ir_in   (ir_in),
        .command (command),
        .address (address),
        .valid   (valid),
        .error   (error),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       samp [MAXS];
    logic       filt [MAXS];
    int         ev   [MAXS];   // 0 none, 1 valid, 2 error
    logic [6:0] evc  [MAXS];
    logic [4:0] eva  [MAXS];
    int         n_samp = 0;

    logic [6:0] cur_cmd = 7'd0;
    logic [4:0] cur_addr = 5'd0;
    int         sc_valid, sc_error;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_level(input logic v, input int n);
        for (int i = 0; i < n; i++)
            if (n_samp < MAXS) begin
                samp[n_samp] = v;
                n_samp++;
            end
    endtask

    task automatic push_frame(input logic [6:0] cmd, input logic [4:0] addr);
        logic [11:0] data;
        data = {addr, cmd};
        push_level(1'b1, 32);
        for (int b = 0; b < 12; b++) begin
            push_level(1'b0, 8);
            push_level(1'b1, data[b] ? 16 : 8);
        end
    endtask

    function automatic int run_len(input int s, input logic v);
        int c = 0;
        while (s + c < n_samp && filt[s + c] == v) c++;
        return c;
    endfunction

    // Decode by run lengths: each burst/gap is measured as a whole and judged against the limits.
    function automatic void model();
        int i, j, k, h, g, b, nb;
        bit done;
        logic [11:0] sh;
        for (int t = 0; t < n_samp; t++) begin
`ifdef IR_GLITCH_FILTER_EN
            int ones;
            ones = 0;
            for (int d = 1; d <= 3; d++) if (t - d >= 0 && samp[t - d]) ones++;
            filt[t] = (ones >= 2);
`else
            filt[t] = samp[t];
`endif
            ev[t] = 0;
        end
        i = 0;
        while (i < n_samp) begin
            if (!filt[i]) begin
                i++;
                continue;
            end
            h = run_len(i, 1'b1);
            if (h > HIGH_MAX) begin
                ev[i + HIGH_MAX] = 2;
                i = i + HIGH_MAX + 1;
                continue;
            end
            if (i + h >= n_samp) break;
            if (h < START_MIN) begin
                i = i + h + 1;
                continue;
            end
            j = i + h; nb = 0; sh = 12'd0; done = 0;
            while (!done) begin
                g = run_len(j, 1'b0);
                if (g > GAP_MAX) begin
                    ev[j + GAP_MAX] = 2; i = j + GAP_MAX + 1; done = 1;
                end else if (j + g >= n_samp) begin
                    i = n_samp; done = 1;
                end else begin
                    k = j + g;
                    b = run_len(k, 1'b1);
                    if (b > HIGH_MAX) begin
                        ev[k + HIGH_MAX] = 2; i = k + HIGH_MAX + 1; done = 1;
                    end else if (k + b >= n_samp) begin
                        i = n_samp; done = 1;
                    end else if (b < ZERO_MIN) begin
                        ev[k + b] = 2; i = k + b + 1; done = 1;
                    end else begin
                        sh[nb] = (b >= ONE_MIN);
                        nb++;
                        if (nb == 12) begin
                            ev[k + b] = 1; evc[k + b] = sh[6:0]; eva[k + b] = sh[11:7];
                            i = k + b + 1; done = 1;
                        end else begin
                            j = k + b;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic run_scenario();
        model();
        sc_valid = 0;
        sc_error = 0;
        for (int i = 0; i < n_samp; i++) begin
            @(negedge clk) ir_in = samp[i];
            repeat (3) @(negedge clk);
            check_eq("hold_valid", valid, 1'b0);
            check_eq("hold_error", error, 1'b0);
            enable = 1'b1;
            @(negedge clk) enable = 1'b0;
            if (ev[i] == 1) begin
                cur_cmd  = evc[i];
                cur_addr = eva[i];
            end
            if (valid) sc_valid++;
            if (error) sc_error++;
            check_eq("valid", valid, ev[i] == 1);
            check_eq("error", error, ev[i] == 2);
            check_eq("command", command, cur_cmd);
            check_eq("address", address, cur_addr);
        end
        n_samp = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd"}, command, 7'd0);
        check_eq({tag, "_addr"}, address, 5'd0);
        check_eq({tag, "_valid"}, valid, 1'b0);
        check_eq({tag, "_error"}, error, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [6:0]  rc;
        logic [4:0]  ra;
        logic [11:0] rd;
        logic [6:0]  prev_cmd;
        logic [4:0]  prev_addr;

        reset  = 1'b1;
        enable = 1'b0;
        ir_in  = 1'b0;
        #1;
        check_reset_outputs("rst_init");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Nominal frame 15/01
        push_frame(7'h15, 5'h01);
        push_level(1'b0, 24);
        run_scenario();
        check_eq("f1_valid_cnt", sc_valid, 1);
        check_eq("f1_error_cnt", sc_error, 0);
        check_eq("f1_cmd", command, 7'h15);
        check_eq("f1_addr", address, 5'h01);
        check_eq("f1_busy", busy, 1'b0);

        // Short noise burst
        push_level(1'b1, 16);
        push_level(1'b0, 24);
        run_scenario();
        check_eq("noise_valid_cnt", sc_valid, 0);
        check_eq("noise_error_cnt", sc_error, 0);
        check_eq("noise_busy", busy, 1'b0);
        check_eq("noise_cmd", command, 7'h15);

        // Start + 3 bits, then a gap that is too long
        push_level(1'b1, 32);
        for (int b = 0; b < 3; b++) begin
            push_level(1'b0, 8);
            push_level(1'b1, 16);
        end
        push_level(1'b0, 30);
        run_scenario();
        check_eq("gap_valid_cnt", sc_valid, 0);
        check_eq("gap_error_cnt", sc_error, 1);
        check_eq("gap_cmd", command, 7'h15);
        check_eq("gap_addr", address, 5'h01);

        // Reset in the middle of bit 6
        push_level(1'b1, 32);
        for (int b = 0; b < 6; b++) begin
            push_level(1'b0, 8);
            push_level(1'b1, 16);
        end
        push_level(1'b0, 8);
        push_level(1'b1, 5);
        run_scenario();
        check_eq("mid_busy", busy, 1'b1);
        @(negedge clk) reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cur_cmd  = 7'd0;
        cur_addr = 5'd0;
        push_frame(7'h7F, 5'h1F);
        push_level(1'b0, 24);
        run_scenario();
        check_eq("rst_valid_cnt", sc_valid, 1);
        check_eq("rst_error_cnt", sc_error, 0);
        check_eq("rst_cmd", command, 7'h7F);
        check_eq("rst_addr", address, 5'h1F);

        // Back-to-back frames
        push_frame(7'h01, 5'h02);
        push_level(1'b0, 8);
        push_frame(7'h02, 5'h03);
        push_level(1'b0, 24);
        run_scenario();
        check_eq("b2b_valid_cnt", sc_valid, 2);
        check_eq("b2b_error_cnt", sc_error, 0);
        check_eq("b2b_cmd", command, 7'h02);
        check_eq("b2b_addr", address, 5'h03);

        // Single-sample glitch in the gap before bit 4
        prev_cmd  = command;
        prev_addr = address;
        rd = {5'h01, 7'h15};
        push_level(1'b1, 32);
        for (int b = 0; b < 12; b++) begin
            if (b == 4) begin
                push_level(1'b0, 3);
                push_level(1'b1, 1);
                push_level(1'b0, 4);
            end else begin
                push_level(1'b0, 8);
            end
            push_level(1'b1, rd[b] ? 16 : 8);
        end
        push_level(1'b0, 24);
        run_scenario();
`ifdef IR_GLITCH_FILTER_EN
        check_eq("glitch_valid_cnt", sc_valid, 1);
        check_eq("glitch_error_cnt", sc_error, 0);
        check_eq("glitch_cmd", command, 7'h15);
        check_eq("glitch_addr", address, 5'h01);
`else
        check_eq("glitch_valid_cnt", sc_valid, 0);
        check_eq("glitch_error_cnt", sc_error, 1);
        check_eq("glitch_cmd", command, prev_cmd);
        check_eq("glitch_addr", address, prev_addr);
`endif

        // Randomized frames with jittered timing around the class boundaries
        for (int f = 0; f < 8; f++) begin
            rc = 7'($urandom);
            ra = 5'($urandom);
            rd = {ra, rc};
            push_level(1'b1, $urandom_range(26, 43));
            for (int b = 0; b < 12; b++) begin
                push_level(1'b0, $urandom_range(3, 18));
                if (rd[b]) push_level(1'b1, $urandom_range(11, 22));
                else       push_level(1'b1, $urandom_range(2, 12));
            end
            push_level(1'b0, 24);
            run_scenario();
            check_eq("rnd_busy", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
